free_release_queue: RTL and testbench
=====================================

# free_release_queue

Commit-side producer for the rename free list. It accepts up to four retired "old physical register" numbers per cycle from the ROB commit stage, compacts and buffers them in a circular queue, and drains up to four per cycle onto the free list's `FreeAble1..4` / `FreeAddr1..4` inputs. The drain is always a contiguous prefix, which is what the free list's write counter requires. The block sits between ROB commit and the FreeList, and follows the same stop, flush and reload protocol as the free list.

## Interface
Parameters:
- `PREGW`, 7, physical register number width (128 registers).
- `DEPTH`, 16, queue entries (power of two).
- `PTRW`, 4, log2(`DEPTH`).

Ports:
- `Clk`  in  1  single clock, rising edge.
- `Rest`  in  1  synchronous, active-high reset.
- `ReleaseStop`  in  1  control-unit stall; freezes draining.
- `ReleaseFlash`  in  1  pipeline flush / ROB reload; discards all queued releases.
- `ReleaseReady`  out  1  to ROB; high when at least 4 entries are free.
- `InRel1Able..InRel4Able`  in  1 each  release valid per commit way; any subset may be set.
- `InRel1Addr..InRel4Addr`  in  `PREGW` each  physical register to release.
- `FreeAble1..FreeAble4`  out  1 each  to FreeList; always a contiguous prefix (1, 12, 123 or 1234).
- `FreeAddr1..FreeAddr4`  out  `PREGW` each  freed register numbers, in queue order.
- `Occupancy`  out  `PTRW+1`  queued entry count.
- `DupError`  out  1  sticky duplicate-release flag; exists only with `FREE_RELEASE_DUP_CHECK_EN`.

## Operation
- Enqueue is accepted only when `ReleaseReady` and not `ReleaseFlash`.
  - Valid ways with `Addr != 0` are compacted in way order 1→4 and written at `WrPtr`, `WrPtr+1`, …
  - Physical register 0 is never released; such ways are dropped silently.
  - `nin` = number written (0..4).
- When `ReleaseReady` is low, all inputs that cycle are ignored. The ROB must hold its commit.
- Dequeue happens when `ReleaseStop` and `ReleaseFlash` are both low.
  - `nout` = min(`Occupancy`, 4).
  - Entries `RdPtr..RdPtr+nout-1` are loaded into output registers: `FreeAble1..nout` = 1 and the rest 0. Unused `FreeAddr` outputs are 0.
- `Occupancy_next = Occupancy + nin - nout`. Pointers advance modulo `DEPTH`, and wrap is seamless: entry `DEPTH-1` is followed by entry 0 within one packet.
- Flush: next cycle `Occupancy` = 0, `WrPtr` = `RdPtr` = 0, all `FreeAble` = 0. Enqueues that cycle are discarded. The FreeList reloads itself from architectural state, so dropping these releases is correct.
- `ReleaseReady = (DEPTH - Occupancy) >= 4`, combinational from registers only, with no path from the current-cycle inputs.

## Timing
- Reset (`Rest` = 1 at the edge):
  - `Occupancy` = 0, pointers = 0.
  - All `FreeAble` = 0, all `FreeAddr` = 0.
  - `ReleaseReady` = 1, `DupError` = 0.
- Latency: a release presented in cycle N is stored at edge N+1. It is dequeued at the earliest in cycle N+1 and appears on `FreeAble` in cycle N+2. There is no bypass.
- Outputs are registered, and each packet is valid for exactly one cycle with no handshake, because the FreeList always accepts.
- `ReleaseStop` sampled high in cycle N gives all `FreeAble` = 0 in cycle N+1. Enqueue continues during stop.
- Enqueue and dequeue in the same cycle are both honoured. A full queue with 4 in and 4 out cannot happen, because `ReleaseReady` is already low.
- `ReleaseFlash` and `ReleaseStop` together: flush wins.
- Reset mid-packet: any output packet in flight is dropped.

## Configuration
- `FREE_RELEASE_DUP_CHECK_EN` defined:
  - Adds a `2**PREGW`-bit queued bitmap. A bit is set on enqueue and cleared on dequeue; flush and reset clear the whole map.
  - A release whose bit is already set, or which matches an earlier way in the same cycle, is dropped and sets the sticky `DupError`.
  - `DupError` clears only on reset.
- Not defined: no bitmap, no `DupError` port. Duplicates are queued as-is.

## Structure
- Shared package/defines:
  - `PREGW` via the existing `ReNameRegBUs` width.
  - The release-packet field layout.
  - The `DEPTH` / `PTRW` constants.
- One sub-module, `release_compactor`: a combinational 4-way valid/zero filter producing the packed addresses and `nin`. Queue, pointers, output registers and the bitmap live in the top module.

## Test plan
- Reset, then `InRel1..4` = {5,6,7,8} all valid → cycle +2: `FreeAble` = 1111, `FreeAddr` = 5,6,7,8; `Occupancy` returns to 0.
- Ways 2 and 4 valid with 9 and 10 → `FreeAble` = 1100, `FreeAddr1` = 9, `FreeAddr2` = 10; way valid with addr 0 → nothing emitted.
- Hold `ReleaseStop`, push 4×3 cycles (12 entries) → `ReleaseReady` drops when `Occupancy` reaches 13 or more. Release stop → packets of 4,4,4 on consecutive cycles.
- Push 14 entries, drain 4/cycle across the 15→0 wrap → order is preserved and contiguous.
- Queue holding 8 entries, `ReleaseFlash` pulse with a simultaneous push → `Occupancy` = 0 and no `FreeAble` for the following 2 cycles.
- With `FREE_RELEASE_DUP_CHECK_EN`: push 20, then 20 again before it drains → a single 20 emitted, `DupError` = 1 and sticky.

Source files
------------

// File: rtl/free_release_queue_pkg.sv
// Shared constants and release-packet layout for the commit-side free release queue.
// Optional duplicate checking is enabled by FREE_RELEASE_DUP_CHECK_EN.
package free_release_queue_pkg;
  localparam int ReNameRegBUs = 7;
  localparam int RelDepth     = 16;
  localparam int RelPtrW      = $clog2(RelDepth);
  localparam int NWAY         = 4;

  typedef struct packed {
    logic                    able;
    logic [ReNameRegBUs-1:0] addr;
  } rel_t;
endpackage

// File: rtl/free_release_queue_if.sv
// Commit-release and free-list drain signals.
// The slave side is the queue. The master side is the ROB together with the FreeList.
interface free_release_queue_if
  import free_release_queue_pkg::*;
#(
  parameter int PREGW = ReNameRegBUs
);
  logic             ReleaseReady;
  logic             InRel1Able, InRel2Able, InRel3Able, InRel4Able;
  logic [PREGW-1:0] InRel1Addr, InRel2Addr, InRel3Addr, InRel4Addr;
  logic             FreeAble1, FreeAble2, FreeAble3, FreeAble4;
  logic [PREGW-1:0] FreeAddr1, FreeAddr2, FreeAddr3, FreeAddr4;

  modport master (
    output InRel1Able, InRel2Able, InRel3Able, InRel4Able,
    output InRel1Addr, InRel2Addr, InRel3Addr, InRel4Addr,
    input  ReleaseReady,
    input  FreeAble1, FreeAble2, FreeAble3, FreeAble4,
    input  FreeAddr1, FreeAddr2, FreeAddr3, FreeAddr4
  );

  modport slave (
    input  InRel1Able, InRel2Able, InRel3Able, InRel4Able,
    input  InRel1Addr, InRel2Addr, InRel3Addr, InRel4Addr,
    output ReleaseReady,
    output FreeAble1, FreeAble2, FreeAble3, FreeAble4,
    output FreeAddr1, FreeAddr2, FreeAddr3, FreeAddr4
  );
endinterface

// File: rtl/free_release_queue_compactor.sv
// Drops invalid ways and ways that release register 0.
// The survivors are packed in way order.
module release_compactor
  import free_release_queue_pkg::*;
#(
  parameter int PREGW = ReNameRegBUs
) (
  input  logic [NWAY-1:0]            able,
  input  logic [NWAY-1:0][PREGW-1:0] addr,
  output logic [NWAY-1:0][PREGW-1:0] paddr,
  output logic [2:0]                 nin
);
  always_comb begin
    paddr = '0;
    nin   = '0;
    for (int i = 0; i < NWAY; i++) begin
      if (able[i] && addr[i] != '0) begin
        paddr[nin[1:0]] = addr[i];
        nin             = nin + 3'd1;
      end
    end
  end
endmodule

// File: rtl/free_release_queue.sv
// Circular buffer between ROB commit and the FreeList.
// It drains a contiguous prefix of up to 4 entries per cycle.
// With FREE_RELEASE_DUP_CHECK_EN, a queued-register bitmap rejects duplicate releases.
module free_release_queue
  import free_release_queue_pkg::*;
#(
  parameter int PREGW = ReNameRegBUs,
  parameter int DEPTH = RelDepth,
  parameter int PTRW  = RelPtrW
) (
  input  logic                 Clk,
  input  logic                 Rest,
  input  logic                 ReleaseStop,
  input  logic                 ReleaseFlash,
  free_release_queue_if.slave  rif,
  output logic [PTRW:0]        Occupancy
`ifdef FREE_RELEASE_DUP_CHECK_EN
  ,
  output logic                 DupError
`endif
);
  logic [NWAY-1:0]            in_able, keep;
  logic [NWAY-1:0][PREGW-1:0] in_addr, cpaddr;
  logic [2:0]                 nin, nin_eff, nout;
  logic                       ready, push, pop;
  logic [PTRW-1:0]            wr_ptr, rd_ptr;
  logic [PREGW-1:0]           mem [DEPTH];
  logic [NWAY-1:0]            out_able;
  logic [NWAY-1:0][PREGW-1:0] out_addr;

  assign in_able = {rif.InRel4Able, rif.InRel3Able, rif.InRel2Able, rif.InRel1Able};
  assign in_addr = {rif.InRel4Addr, rif.InRel3Addr, rif.InRel2Addr, rif.InRel1Addr};

  // Ready depends only on registered occupancy, so nothing from the ROB can loop back into it.
  assign ready            = Occupancy <= (PTRW+1)'(DEPTH - NWAY);
  assign rif.ReleaseReady = ready;
  assign push             = ready & ~ReleaseFlash;
  assign pop              = ~ReleaseStop & ~ReleaseFlash;
  assign nin_eff          = push ? nin : 3'd0;
  assign nout             = !pop ? 3'd0 :
                            (Occupancy >= (PTRW+1)'(NWAY)) ? 3'd4 : Occupancy[2:0];

`ifdef FREE_RELEASE_DUP_CHECK_EN
  logic [(1<<PREGW)-1:0] qmap;
  logic                  dup_seen;

  always_comb begin
    keep     = in_able;
    dup_seen = 1'b0;
    for (int i = 0; i < NWAY; i++) begin
      logic hit;
      hit = qmap[in_addr[i]];
      for (int j = 0; j < i; j++)
        if (in_able[j] && in_addr[j] == in_addr[i]) hit = 1'b1;
      if (in_able[i] && in_addr[i] != '0 && hit) begin
        keep[i]  = 1'b0;
        dup_seen = 1'b1;
      end
    end
  end

  // Clear bits on dequeue first, then set bits on enqueue. The duplicate filter keeps the two sets disjoint.
  always_ff @(posedge Clk) begin
    if (Rest || ReleaseFlash) begin
      qmap <= '0;
    end else begin
      for (int i = 0; i < NWAY; i++)
        if (3'(i) < nout) qmap[mem[rd_ptr + PTRW'(i)]] <= 1'b0;
      for (int i = 0; i < NWAY; i++)
        if (3'(i) < nin_eff) qmap[cpaddr[i]] <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest)                  DupError <= 1'b0;
    else if (push && dup_seen) DupError <= 1'b1;
  end
`else
  assign keep = in_able;
`endif

  release_compactor #(.PREGW(PREGW)) u_cmp (
    .able  (keep),
    .addr  (in_addr),
    .paddr (cpaddr),
    .nin   (nin)
  );

  always_ff @(posedge Clk) begin
    for (int i = 0; i < NWAY; i++)
      if (3'(i) < nin_eff) mem[wr_ptr + PTRW'(i)] <= cpaddr[i];
  end

  always_ff @(posedge Clk) begin
    if (Rest || ReleaseFlash) begin
      Occupancy <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_able  <= '0;
      out_addr  <= '0;
    end else begin
      for (int i = 0; i < NWAY; i++) begin
        out_able[i] <= 3'(i) < nout;
        out_addr[i] <= (3'(i) < nout) ? mem[rd_ptr + PTRW'(i)] : '0;
      end
      wr_ptr    <= wr_ptr + PTRW'(nin_eff);
      rd_ptr    <= rd_ptr + PTRW'(nout);
      Occupancy <= Occupancy + (PTRW+1)'(nin_eff) - (PTRW+1)'(nout);
    end
  end

  assign rif.FreeAble1 = out_able[0];
  assign rif.FreeAble2 = out_able[1];
  assign rif.FreeAble3 = out_able[2];
  assign rif.FreeAble4 = out_able[3];
  assign rif.FreeAddr1 = out_addr[0];
  assign rif.FreeAddr2 = out_addr[1];
  assign rif.FreeAddr3 = out_addr[2];
  assign rif.FreeAddr4 = out_addr[3];
endmodule

// File: tb/tb_free_release_queue.sv
// Directed bench for free_release_queue.
// It covers both builds, with and without FREE_RELEASE_DUP_CHECK_EN.
module tb_free_release_queue;
  logic       Clk = 1'b0;
  logic       Rest, ReleaseStop, ReleaseFlash;
  logic [4:0] Occupancy;
`ifdef FREE_RELEASE_DUP_CHECK_EN
  logic       DupError;
`endif
  int total = 0;
  int bad   = 0;

  free_release_queue_if #(.PREGW(7)) rif();

  free_release_queue dut (
    .Clk          (Clk),
    .Rest         (Rest),
    .ReleaseStop  (ReleaseStop),
    .ReleaseFlash (ReleaseFlash),
    .rif          (rif),
    .Occupancy    (Occupancy)
`ifdef FREE_RELEASE_DUP_CHECK_EN
    ,
    .DupError     (DupError)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // en[3] is way 1 and en[0] is way 4, so 4'b1100 reads as "ways 1,2".
  task automatic drive(input logic [3:0] en, input logic [6:0] a1, a2, a3, a4);
    rif.InRel1Able = en[3]; rif.InRel2Able = en[2];
    rif.InRel3Able = en[1]; rif.InRel4Able = en[0];
    rif.InRel1Addr = a1; rif.InRel2Addr = a2;
    rif.InRel3Addr = a3; rif.InRel4Addr = a4;
  endtask

  task automatic idle();
    drive(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkpkt(input string tag, input logic [3:0] fa, input logic [6:0] a1, a2, a3, a4);
    chk({tag, ".able"}, {28'd0, rif.FreeAble1, rif.FreeAble2, rif.FreeAble3, rif.FreeAble4}, {28'd0, fa});
    chk({tag, ".addr"}, {4'd0, rif.FreeAddr1, rif.FreeAddr2, rif.FreeAddr3, rif.FreeAddr4},
        {4'd0, a1, a2, a3, a4});
  endtask

  task automatic chkfa0(input string tag);
    chk(tag, {28'd0, rif.FreeAble1, rif.FreeAble2, rif.FreeAble3, rif.FreeAble4}, 32'd0);
  endtask

  initial begin
    Rest = 1'b1; ReleaseStop = 1'b0; ReleaseFlash = 1'b0;
    idle();
    tick(); tick();
    chk("rst.occ", 32'(Occupancy), 32'd0);
    chkpkt("rst.pkt", 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    chk("rst.ready", 32'(rif.ReleaseReady), 32'd1);
`ifdef FREE_RELEASE_DUP_CHECK_EN
    chk("rst.dup", 32'(DupError), 32'd0);
`endif
    Rest = 1'b0;

    // Four-wide release: the packet appears two edges after it is presented.
    drive(4'b1111, 7'd5, 7'd6, 7'd7, 7'd8); tick();
    chk("s1.occ", 32'(Occupancy), 32'd4);
    chkfa0("s1.nobypass");
    idle(); tick();
    chkpkt("s1.pkt", 4'b1111, 7'd5, 7'd6, 7'd7, 7'd8);
    chk("s1.occ0", 32'(Occupancy), 32'd0);
    tick();
    chkfa0("s1.after");

    // Sparse ways and zero-register filtering.
    drive(4'b0101, 7'd0, 7'd9, 7'd0, 7'd10); tick();
    chk("s2.occ", 32'(Occupancy), 32'd2);
    idle(); tick();
    chkpkt("s2.pkt", 4'b1100, 7'd9, 7'd10, 7'd0, 7'd0);
    drive(4'b0010, 7'd0, 7'd0, 7'd0, 7'd0); tick();
    chk("s2.zero.occ", 32'(Occupancy), 32'd0);
    idle(); tick();
    chkfa0("s2.zero.fa");
    drive(4'b1111, 7'd0, 7'd11, 7'd0, 7'd12); tick();
    chk("s2.mix.occ", 32'(Occupancy), 32'd2);
    idle(); tick();
    chkpkt("s2.mix.pkt", 4'b1100, 7'd11, 7'd12, 7'd0, 7'd0);

    // Stop held while filling, then the ready threshold, then the drain.
    ReleaseStop = 1'b1;
    drive(4'b1111, 7'd20, 7'd21, 7'd22, 7'd23); tick();
    chk("s3.occ4", 32'(Occupancy), 32'd4);
    chkfa0("s3.stopfa");
    drive(4'b1111, 7'd24, 7'd25, 7'd26, 7'd27); tick();
    chk("s3.occ8", 32'(Occupancy), 32'd8);
    drive(4'b1111, 7'd28, 7'd29, 7'd30, 7'd31); tick();
    chk("s3.occ12", 32'(Occupancy), 32'd12);
    chk("s3.rdy12", 32'(rif.ReleaseReady), 32'd1);
    drive(4'b1000, 7'd32, 7'd0, 7'd0, 7'd0); tick();
    chk("s3.occ13", 32'(Occupancy), 32'd13);
    chk("s3.rdy13", 32'(rif.ReleaseReady), 32'd0);
    drive(4'b1111, 7'd33, 7'd34, 7'd35, 7'd36); tick();
    chk("s3.ignored", 32'(Occupancy), 32'd13);
    ReleaseStop = 1'b0; idle(); tick();
    chkpkt("s3.p1", 4'b1111, 7'd20, 7'd21, 7'd22, 7'd23);
    chk("s3.occ9", 32'(Occupancy), 32'd9);
    tick();
    chkpkt("s3.p2", 4'b1111, 7'd24, 7'd25, 7'd26, 7'd27);
    tick();
    chkpkt("s3.p3", 4'b1111, 7'd28, 7'd29, 7'd30, 7'd31);
    tick();
    chkpkt("s3.p4", 4'b1000, 7'd32, 7'd0, 7'd0, 7'd0);
    chk("s3.occ0", 32'(Occupancy), 32'd0);

    // Both pointers now sit at 5, so 14 entries cross the 15->0 wrap inside the third packet.
    ReleaseStop = 1'b1;
    drive(4'b1111, 7'd40, 7'd41, 7'd42, 7'd43); tick();
    drive(4'b1111, 7'd44, 7'd45, 7'd46, 7'd47); tick();
    drive(4'b1111, 7'd48, 7'd49, 7'd50, 7'd51); tick();
    drive(4'b1100, 7'd52, 7'd53, 7'd0, 7'd0); tick();
    chk("s4.occ14", 32'(Occupancy), 32'd14);
    ReleaseStop = 1'b0; idle(); tick();
    chkpkt("s4.p1", 4'b1111, 7'd40, 7'd41, 7'd42, 7'd43);
    tick();
    chkpkt("s4.p2", 4'b1111, 7'd44, 7'd45, 7'd46, 7'd47);
    tick();
    chkpkt("s4.p3", 4'b1111, 7'd48, 7'd49, 7'd50, 7'd51);
    tick();
    chkpkt("s4.p4", 4'b1100, 7'd52, 7'd53, 7'd0, 7'd0);
    chk("s4.occ0", 32'(Occupancy), 32'd0);

    // Enqueue and dequeue in the same cycle.
    drive(4'b1111, 7'd90, 7'd91, 7'd92, 7'd93); tick();
    drive(4'b1000, 7'd94, 7'd0, 7'd0, 7'd0); tick();
    chkpkt("s5.p1", 4'b1111, 7'd90, 7'd91, 7'd92, 7'd93);
    chk("s5.occ1", 32'(Occupancy), 32'd1);
    idle(); tick();
    chkpkt("s5.p2", 4'b1000, 7'd94, 7'd0, 7'd0, 7'd0);

    // Flush while 8 entries are queued, with a push and a stop in the same cycle.
    ReleaseStop = 1'b1;
    drive(4'b1111, 7'd60, 7'd61, 7'd62, 7'd63); tick();
    drive(4'b1111, 7'd64, 7'd65, 7'd66, 7'd67); tick();
    chk("s6.occ8", 32'(Occupancy), 32'd8);
    ReleaseFlash = 1'b1;
    drive(4'b1111, 7'd70, 7'd71, 7'd72, 7'd73); tick();
    chk("s6.occ0", 32'(Occupancy), 32'd0);
    chkfa0("s6.fa.c0");
    ReleaseFlash = 1'b0; ReleaseStop = 1'b0; idle(); tick();
    chkfa0("s6.fa.c1");
    chk("s6.occ.c1", 32'(Occupancy), 32'd0);
    tick();
    chkfa0("s6.fa.c2");
    drive(4'b1000, 7'd80, 7'd0, 7'd0, 7'd0); tick();
    chk("s6.re.occ", 32'(Occupancy), 32'd1);
    idle(); tick();
    chkpkt("s6.re.pkt", 4'b1000, 7'd80, 7'd0, 7'd0, 7'd0);

    // Duplicate releases.
    ReleaseStop = 1'b1;
    drive(4'b1000, 7'd20, 7'd0, 7'd0, 7'd0); tick();
    chk("s7.occ1", 32'(Occupancy), 32'd1);
    drive(4'b1000, 7'd20, 7'd0, 7'd0, 7'd0); tick();
`ifdef FREE_RELEASE_DUP_CHECK_EN
    chk("s7.dup.occ", 32'(Occupancy), 32'd1);
    chk("s7.dup.flag", 32'(DupError), 32'd1);
    drive(4'b1100, 7'd21, 7'd21, 7'd0, 7'd0); tick();
    chk("s7.same.occ", 32'(Occupancy), 32'd2);
    ReleaseStop = 1'b0; idle(); tick();
    chkpkt("s7.pkt", 4'b1100, 7'd20, 7'd21, 7'd0, 7'd0);
    tick();
    chkfa0("s7.after");
    chk("s7.sticky", 32'(DupError), 32'd1);
`else
    chk("s7.nodup.occ", 32'(Occupancy), 32'd2);
    ReleaseStop = 1'b0; idle(); tick();
    chkpkt("s7.pkt", 4'b1100, 7'd20, 7'd20, 7'd0, 7'd0);
`endif

    // Reset while a packet is about to drain.
    drive(4'b1111, 7'd100, 7'd101, 7'd102, 7'd103); tick();
    chk("s8.occ4", 32'(Occupancy), 32'd4);
    idle(); Rest = 1'b1; tick();
    chkpkt("s8.pkt", 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    chk("s8.occ0", 32'(Occupancy), 32'd0);
    chk("s8.ready", 32'(rif.ReleaseReady), 32'd1);
`ifdef FREE_RELEASE_DUP_CHECK_EN
    chk("s8.dup", 32'(DupError), 32'd0);
`endif
    Rest = 1'b0; tick();
    chkfa0("s8.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
